// File: rtl/pwm_dac.sv
// PWM output stage for the DDS voice path: captures the Mult product on an update edge,
// rounds/saturates it to OUT_W bits, double-buffers it and drives a glitch-free PWM bit.
module pwm_dac #(
    parameter int M     = 12,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*M-1:0]   mult,
    input  logic             update,
    input  logic             clr_ovr,
    output logic             pwm_out,
    output logic             sample_taken,
    output logic             period_start,
    output logic             overrun
);

    localparam logic [OUT_W-1:0] CNT_MAX  = '1;
    localparam logic [2*M:0]     HALF_LSB = (2*M+1)'(1) << (2*M-OUT_W-1);

    // Adding half an output LSB before truncating is the same as top + rb; the extra MSB carries overflow.
    function automatic logic [OUT_W:0] round_top(input logic [2*M-1:0] p);
        return (OUT_W+1)'(({1'b0, p} + HALF_LSB) >> (2*M-OUT_W));
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic [OUT_W:0] s);
        return s[OUT_W] ? CNT_MAX : s[OUT_W-1:0];
    endfunction

    logic [OUT_W-1:0] cnt;
    logic [OUT_W-1:0] duty;
    logic [OUT_W-1:0] pending;
    logic             pend_v;
    logic             update_d;

    logic             cap_p0;
    logic             wrap_p0;
    logic [OUT_W-1:0] rnd_p0;
    logic [OUT_W-1:0] cnt_nxt;
    logic [OUT_W-1:0] duty_nxt;
    logic             pend_v_nxt;
    logic             ovr_set;

    // Stage p0: capture decode, buffer hand-over and next duty selection
    always_comb begin
        cap_p0     = update & ~update_d;
        wrap_p0    = (cnt == CNT_MAX);
        rnd_p0     = sat_out(round_top(mult));
        cnt_nxt    = cnt + 1'b1;
        duty_nxt   = duty;
        pend_v_nxt = pend_v;
        ovr_set    = 1'b0;
        if (wrap_p0) begin
            if (cap_p0) begin
                duty_nxt = rnd_p0;
            end else if (pend_v) begin
                duty_nxt = pending;
            end
            pend_v_nxt = 1'b0;
        end else if (cap_p0) begin
            pend_v_nxt = 1'b1;
            ovr_set    = pend_v;
        end
    end

    // Stage p1: registered state and outputs; pwm_out compares the position it is about to enter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            duty         <= '0;
            pending      <= '0;
            pend_v       <= 1'b0;
            update_d     <= 1'b0;
            pwm_out      <= 1'b0;
            sample_taken <= 1'b0;
            period_start <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            update_d     <= update;
            cnt          <= cnt_nxt;
            duty         <= duty_nxt;
            pend_v       <= pend_v_nxt;
            if (cap_p0) begin
                pending <= rnd_p0;
            end
            sample_taken <= cap_p0;
            period_start <= wrap_p0;
            pwm_out      <= (cnt_nxt < duty_nxt);
            overrun      <= ovr_set | (overrun & ~clr_ovr);
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Scoreboard bench for pwm_dac: a period-level reference model predicts each period's duty
// and the per-cycle strobes; a negedge monitor measures every PWM period and compares.
module tb_pwm_dac;

    localparam int M     = 12;
    localparam int OUT_W = 8;
    localparam int PER   = 1 << OUT_W;

    logic           clk     = 1'b0;
    logic           rst     = 1'b1;
    logic           update  = 1'b0;
    logic           clr_ovr = 1'b0;
    logic [2*M-1:0] mult    = '0;
    logic           pwm_out;
    logic           sample_taken;
    logic           period_start;
    logic           overrun;

    int checks = 0;
    int errors = 0;

    pwm_dac #(.M(M), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mult         (mult),
        .update       (update),
        .clr_ovr      (clr_ovr),
        .pwm_out      (pwm_out),
        .sample_taken (sample_taken),
        .period_start (period_start),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Level the product should produce: nearest OUT_W-bit step, clipped at full scale
    function automatic int ref_level(input logic [2*M-1:0] p);
        int v;
        v = (int'(p) + (1 << (2*M-OUT_W-1))) >> (2*M-OUT_W);
        if (v > PER-1) v = PER-1;
        return v;
    endfunction

    // Reference model: the duty of each period is the last product captured during the
    // previous period (its final clock included); with no capture the old duty repeats.
    int  edge_cnt;
    int  early_n;
    int  cur_duty;
    int  last_val;
    bit  have_new;
    bit  upd_prev;
    bit  exp_st;
    bit  exp_ps;
    bit  exp_ovr;
    int  exp_q[$];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            edge_cnt = 0;
            early_n  = 0;
            cur_duty = 0;
            last_val = 0;
            have_new = 0;
            upd_prev = 0;
            exp_st   = 0;
            exp_ps   = 0;
            exp_ovr  = 0;
            exp_q.delete();
        end else begin
            int  phase;
            bit  cap;
            bit  ovr_evt;
            phase   = edge_cnt % PER;
            cap     = update && !upd_prev;
            upd_prev = update;
            exp_st  = cap;
            exp_ps  = (phase == PER-1);
            ovr_evt = 0;
            if (cap) begin
                last_val = ref_level(mult);
                have_new = 1;
                if (phase != PER-1) begin
                    if (early_n > 0) ovr_evt = 1;
                    early_n++;
                end
            end
            if (ovr_evt) exp_ovr = 1;
            else if (clr_ovr) exp_ovr = 0;
            if (phase == PER-1) begin
                if (have_new) cur_duty = last_val;
                exp_q.push_back(cur_duty);
                have_new = 0;
                early_n  = 0;
            end
            edge_cnt++;
        end
    end

    // Monitor: per-cycle strobes, plus high-time and shape of every full PWM period
    int mon_pos;
    int hi_cnt;
    int periods_checked = 0;
    bit mon_act = 0;
    bit seen_low;
    bit shape_ok;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mon_act = 0;
        end else begin
            check("sample_taken", int'(sample_taken), int'(exp_st));
            check("period_start", int'(period_start), int'(exp_ps));
            check("overrun", int'(overrun), int'(exp_ovr));
            if (period_start) begin
                mon_act  = 1;
                mon_pos  = 0;
                hi_cnt   = 0;
                seen_low = 0;
                shape_ok = 1;
            end
            if (mon_act) begin
                if (pwm_out) begin
                    hi_cnt++;
                    if (seen_low) shape_ok = 0;
                end else begin
                    seen_low = 1;
                end
                mon_pos++;
                if (mon_pos == PER) begin
                    mon_act = 0;
                    periods_checked++;
                    check("pwm_expect_avail", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        int exp_d;
                        exp_d = exp_q.pop_front();
                        check("pwm_high_clocks", hi_cnt, exp_d);
                        check("pwm_contiguous", int'(shape_ok), 1);
                    end
                end
            end
        end
    end

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((edge_cnt % PER) != p && n < 4*PER);
        check("wait_phase", edge_cnt % PER, p);
    endtask

    task automatic pulse(input logic [2*M-1:0] v, input int len);
        mult   = v;
        update = 1'b1;
        repeat (len) @(negedge clk);
        update = 1'b0;
        mult   = (2*M)'($urandom());
    endtask

    task automatic idle_periods(input int n);
        repeat (n*PER) @(negedge clk);
    endtask

    task automatic clr_pulse();
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_sample_taken", int'(sample_taken), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // Half scale, rounding boundaries, saturation and zero
        wait_phase(20);  pulse(24'h800000, 1); idle_periods(2);
        wait_phase(40);  pulse(24'h7F8000, 1); idle_periods(2);
        wait_phase(40);  pulse(24'h7F7FFF, 1); idle_periods(2);
        wait_phase(60);  pulse(24'hFFFFFF, 1); idle_periods(2);
        wait_phase(60);  pulse(24'h000000, 1); idle_periods(2);

        // Two captures in one period: newer wins and overrun latches
        wait_phase(10);  pulse(24'h400000, 1);
        wait_phase(50);  pulse(24'hC00000, 1);
        @(negedge clk);
        check("overrun_latched", int'(overrun), 1);
        idle_periods(2);
        wait_phase(5);   clr_pulse();
        @(negedge clk);
        check("overrun_cleared", int'(overrun), 0);

        // Pending sample followed by a capture on the wrap clock: bypass, no overrun
        wait_phase(100); pulse(24'h300000, 1);
        wait_phase(255); pulse(24'h500000, 1);
        @(negedge clk);
        check("wrap_capture_no_overrun", int'(overrun), 0);
        idle_periods(2);

        // Clear and a new overrun on the same clock: set wins
        wait_phase(10);  pulse(24'h600000, 1);
        wait_phase(60);  clr_ovr = 1'b1; pulse(24'h700000, 1); clr_ovr = 1'b0;
        @(negedge clk);
        check("overrun_set_wins", int'(overrun), 1);
        clr_pulse();
        idle_periods(1);

        // Held update produces a single capture
        wait_phase(30);  pulse(24'h200000, 20); idle_periods(2);

        // Randomized products, spacing, pulse lengths and clears
        for (int i = 0; i < 40; i++) begin
            logic [2*M-1:0] v;
            repeat ($urandom_range(1, 300)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) clr_pulse();
            case ($urandom_range(0, 3))
                0:       v = {8'hFF, 16'($urandom())};
                1:       v = {8'h00, 16'($urandom())};
                default: v = (2*M)'($urandom());
            endcase
            pulse(v, $urandom_range(1, 3));
        end
        idle_periods(2);

        // Reset in the middle of a high phase, with overrun set
        wait_phase(10);  pulse(24'hC80000, 1);
        wait_phase(20);  pulse(24'h100000, 1);
        wait_phase(30);  pulse(24'hC80000, 1);
        wait_phase(200);
        wait_phase(100);
        check("pwm_high_before_rst", int'(pwm_out), 1);
        check("overrun_before_rst", int'(overrun), 1);
        #1 rst = 1'b1;
        #1;
        check("pwm_async_rst", int'(pwm_out), 0);
        check("overrun_async_rst", int'(overrun), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_period_start", int'(period_start), 0);
        rst = 1'b0;
        idle_periods(3);

        check("periods_seen_enough", int'(periods_checked > 40), 1);
        check("scoreboard_residual", exp_q.size(), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
